// File: rtl/instr_encoder.sv
// LEGv8 program loader: assembles symbolic instruction fields into
// 32-bit machine words and writes them sequentially to instruction memory.
module instr_encoder #(
  parameter int          ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          DEPTH     = 256,
  parameter int          CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [25:0]       imm,
  input  logic [1:0]        hw,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ready,
  output logic              err,
  output logic              full,
  output logic [CNT_W-1:0]  word_count
);

  typedef enum logic [2:0] {
    IDLE, READY, ENCODE, WRITE, FULL
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(DEPTH - 1);

  state_t      state;
  logic [3:0]  op_q;
  logic [4:0]  rd_q;
  logic [4:0]  rn_q;
  logic [4:0]  rm_q;
  logic [25:0] imm_q;
  logic [1:0]  hw_q;

  logic [31:0] word;
  logic        ok;
  logic        s19;
  logic        s9;
  logic        rewind;

  // imm19 / imm9 fit when all bits above the field are sign copies
  assign s19 = (&imm_q[25:18]) | ~(|imm_q[25:18]);
  assign s9  = (&imm_q[25:8]) | ~(|imm_q[25:8]);

  assign rewind = start &&
    (state == IDLE || state == READY || state == FULL);

  // Encode the latched fields and judge their range
  always_comb begin
    word = '0;
    ok   = 1'b0;
    case (op_q)
      4'd0: begin
        word = {10'b1001000100, imm_q[11:0], rn_q, rd_q};
        ok   = ~(|imm_q[25:12]);
      end
      4'd1: begin
        word = {11'b10101011000, rm_q, 6'b0, rn_q, rd_q};
        ok   = 1'b1;
      end
      4'd2: begin
        word = {6'b000101, imm_q};
        ok   = 1'b1;
      end
      4'd3: begin
        word = {8'b01010100, imm_q[18:0], 5'b01011};
        ok   = s19;
      end
      4'd4: begin
        word = {8'b10110100, imm_q[18:0], rd_q};
        ok   = s19;
      end
      4'd5: begin
        word = {11'b11111000010, imm_q[8:0], 2'b00, rn_q, rd_q};
        ok   = s9;
      end
      4'd6: begin
        word = {11'b00111000010, imm_q[8:0], 2'b00, rn_q, rd_q};
        ok   = s9;
      end
      4'd7: begin
        word = {9'b111100101, hw_q, imm_q[15:0], rd_q};
        ok   = ~(|imm_q[25:16]);
      end
      4'd8: begin
        word = {9'b110100101, hw_q, imm_q[15:0], rd_q};
        ok   = ~(|imm_q[25:16]);
      end
      4'd9: begin
        word = {11'b11111000000, imm_q[8:0], 2'b00, rn_q, rd_q};
        ok   = s9;
      end
      4'd10: begin
        word = {11'b00111000000, imm_q[8:0], 2'b00, rn_q, rd_q};
        ok   = s9;
      end
      4'd11: begin
        word = {11'b11101011000, rm_q, 6'b0, rn_q, rd_q};
        ok   = 1'b1;
      end
      default: begin
        word = '0;
        ok   = 1'b0;
      end
    endcase
  end

  // Loader FSM with registered handshake and memory outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= BASE;
      wr_data    <= '0;
      err        <= 1'b0;
      full       <= 1'b0;
      word_count <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      rn_q       <= '0;
      rm_q       <= '0;
      imm_q      <= '0;
      hw_q       <= '0;
    end else begin
      err <= 1'b0;
      if (rewind) begin
        state      <= READY;
        in_ready   <= 1'b1;
        wr_addr    <= BASE;
        word_count <= '0;
        full       <= 1'b0;
      end else begin
        case (state)
          READY: begin
            if (in_valid && in_ready) begin
              op_q     <= op;
              rd_q     <= rd;
              rn_q     <= rn;
              rm_q     <= rm;
              imm_q    <= imm;
              hw_q     <= hw;
              in_ready <= 1'b0;
              state    <= ENCODE;
            end
          end
          ENCODE: begin
            if (ok) begin
              wr_data <= word;
              wr_en   <= 1'b1;
              state   <= WRITE;
            end else begin
              err      <= 1'b1;
              in_ready <= 1'b1;
              state    <= READY;
            end
          end
          WRITE: begin
            if (wr_ready) begin
              wr_en      <= 1'b0;
              wr_addr    <= wr_addr + ADDR_W'(4);
              word_count <= word_count + CNT_W'(1);
              if (word_count == LAST) begin
                full  <= 1'b1;
                state <= FULL;
              end else begin
                in_ready <= 1'b1;
                state    <= READY;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table of single instructions
// plus hand sequences for stalls, errors, full and reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [25:0] imm;
  logic [1:0]  hw;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        err;
  logic        full;
  logic [2:0]  word_count;

  int ncmp = 0;
  int nbad = 0;

  instr_encoder #(
    .ADDR_W(16), .BASE_ADDR(0), .DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rn(rn), .rm(rm),
    .imm(imm), .hw(hw),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready),
    .err(err), .full(full), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [25:0] imm;
    logic [1:0]  hw;
    logic        bad;
    logic [31:0] data;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] o, input logic [4:0] d,
                      input logic [4:0] n, input logic [4:0] m,
                      input logic [25:0] i, input logic [1:0] h);
    int lat;
    op = o; rd = d; rn = n; rm = m; imm = i; hw = h;
    in_valid = 1'b1;
    chk("in_ready_before", {31'b0, in_ready}, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!wr_en && !err && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 1);
  endtask

  task automatic complete();
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready = 1'b0;
  endtask

  initial begin
    vt[0]  = '{4'd0,  5'd1, 5'd2, 5'd0, 26'd5,        2'd0, 1'b0, 32'h91001441};
    vt[1]  = '{4'd1,  5'd4, 5'd5, 5'd6, 26'd0,        2'd0, 1'b0, 32'hAB0600A4};
    vt[2]  = '{4'd3,  5'd0, 5'd0, 5'd0, 26'h3FFFFFF,  2'd0, 1'b0, 32'h54FFFFEB};
    vt[3]  = '{4'd4,  5'd7, 5'd0, 5'd0, 26'd3,        2'd0, 1'b0, 32'hB4000067};
    vt[4]  = '{4'd6,  5'd2, 5'd3, 5'd0, 26'h3FFFFFE,  2'd0, 1'b0, 32'h385FE062};
    vt[5]  = '{4'd9,  5'd1, 5'd2, 5'd0, 26'd8,        2'd0, 1'b0, 32'hF8008041};
    vt[6]  = '{4'd10, 5'd0, 5'd0, 5'd0, 26'd255,      2'd0, 1'b0, 32'h380FF000};
    vt[7]  = '{4'd7,  5'd5, 5'd0, 5'd0, 26'h1234,     2'd3, 1'b0, 32'hF2E24685};
    vt[8]  = '{4'd0,  5'd0, 5'd0, 5'd0, 26'd4095,     2'd0, 1'b0, 32'h913FFC00};
    vt[9]  = '{4'd5,  5'd0, 5'd0, 5'd0, 26'd255,      2'd0, 1'b0, 32'hF84FF000};
    vt[10] = '{4'd0,  5'd0, 5'd0, 5'd0, 26'd4096,     2'd0, 1'b1, 32'h0};
    vt[11] = '{4'd0,  5'd0, 5'd0, 5'd0, 26'h3FFFFFF,  2'd0, 1'b1, 32'h0};
    vt[12] = '{4'd3,  5'd0, 5'd0, 5'd0, 26'h40000,    2'd0, 1'b1, 32'h0};
    vt[13] = '{4'd8,  5'd0, 5'd0, 5'd0, 26'h10000,    2'd0, 1'b1, 32'h0};
    vt[14] = '{4'd10, 5'd0, 5'd0, 5'd0, 26'd256,      2'd0, 1'b1, 32'h0};
    vt[15] = '{4'd13, 5'd0, 5'd0, 5'd0, 26'd0,        2'd0, 1'b1, 32'h0};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    op = '0; rd = '0; rn = '0; rm = '0; imm = '0; hw = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_wr_en", {31'b0, wr_en}, 0);
    chk("rst_addr", {16'b0, wr_addr}, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_full", {31'b0, full}, 0);
    chk("rst_count", {29'b0, word_count}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {31'b0, in_ready}, 0);

    for (int k = 0; k < 16; k++) begin
      do_start();
      send(vt[k].op, vt[k].rd, vt[k].rn, vt[k].rm, vt[k].imm, vt[k].hw);
      chk($sformatf("v%0d_err", k), {31'b0, err}, {31'b0, vt[k].bad});
      chk($sformatf("v%0d_wr_en", k), {31'b0, wr_en}, {31'b0, ~vt[k].bad});
      if (!vt[k].bad) begin
        chk($sformatf("v%0d_data", k), wr_data, vt[k].data);
        chk($sformatf("v%0d_addr", k), {16'b0, wr_addr}, 0);
        complete();
        chk($sformatf("v%0d_count", k), {29'b0, word_count}, 1);
        chk($sformatf("v%0d_addr_next", k), {16'b0, wr_addr}, 4);
      end else begin
        chk($sformatf("v%0d_rdy", k), {31'b0, in_ready}, 1);
        @(negedge clk);
        chk($sformatf("v%0d_err_pulse", k), {31'b0, err}, 0);
      end
    end

    // SUBS then B: consecutive addresses
    do_start();
    send(4'd11, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0);
    chk("subs_data", wr_data, 32'hEB020023);
    chk("subs_addr", {16'b0, wr_addr}, 0);
    complete();
    send(4'd2, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 2'd0);
    chk("b_data", wr_data, 32'h17FFFFFF);
    chk("b_addr", {16'b0, wr_addr}, 4);
    complete();
    chk("sb_count", {29'b0, word_count}, 2);

    // MOVZ with wr_ready stalled three cycles
    do_start();
    send(4'd8, 5'd0, 5'd0, 5'd0, 26'hBEEF, 2'd1);
    for (int s = 0; s < 3; s++) begin
      chk("stall_wr_en", {31'b0, wr_en}, 1);
      chk("stall_addr", {16'b0, wr_addr}, 0);
      chk("stall_data", wr_data, 32'hD2B7DDE0);
      @(negedge clk);
    end
    complete();
    chk("stall_done_wr_en", {31'b0, wr_en}, 0);
    chk("stall_count", {29'b0, word_count}, 1);

    // Two rejections in a row
    do_start();
    send(4'd5, 5'd0, 5'd0, 5'd0, 26'd256, 2'd0);
    chk("ldur_err", {31'b0, err}, 1);
    chk("ldur_wr_en", {31'b0, wr_en}, 0);
    @(negedge clk);
    send(4'd12, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0);
    chk("op12_err", {31'b0, err}, 1);
    chk("op12_rdy", {31'b0, in_ready}, 1);
    chk("rej_addr", {16'b0, wr_addr}, 0);
    chk("rej_count", {29'b0, word_count}, 0);
    @(negedge clk);

    // start beats in_valid in the same READY cycle
    start = 1'b1; in_valid = 1'b1;
    op = 4'd0; imm = 26'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("startwin_wr_en", {31'b0, wr_en}, 0);
    chk("startwin_rdy", {31'b0, in_ready}, 1);

    // Fill to DEPTH=4, fifth is refused
    do_start();
    for (int j = 0; j < 4; j++) begin
      send(4'd0, 5'(j), 5'd0, 5'd0, 26'(j), 2'd0);
      chk("fill_addr", {16'b0, wr_addr}, 32'(4 * j));
      complete();
    end
    chk("full_flag", {31'b0, full}, 1);
    chk("full_rdy", {31'b0, in_ready}, 0);
    chk("full_count", {29'b0, word_count}, 4);
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("full_no_write", {31'b0, wr_en}, 0);
    chk("full_still", {31'b0, full}, 1);
    in_valid = 1'b0;
    do_start();
    chk("restart_addr", {16'b0, wr_addr}, 0);
    chk("restart_count", {29'b0, word_count}, 0);
    chk("restart_rdy", {31'b0, in_ready}, 1);
    chk("restart_full", {31'b0, full}, 0);

    // Reset in the middle of a write
    send(4'd0, 5'd1, 5'd2, 5'd0, 26'd5, 2'd0);
    chk("pre_rst_wr_en", {31'b0, wr_en}, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_en", {31'b0, wr_en}, 0);
    chk("mid_rst_data", wr_data, 0);
    chk("mid_rst_addr", {16'b0, wr_addr}, 0);
    chk("mid_rst_count", {29'b0, word_count}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_rdy", {31'b0, in_ready}, 0);
    chk("post_rst_wr_en", {31'b0, wr_en}, 0);
    do_start();
    chk("post_rst_start", {31'b0, in_ready}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
